pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline: drives write-enable and flush of PC, IF/ID, ID/EX, EX/MEM and MEM/WB buffer registers.
- Resolves load-use hazards, taken-branch redirects, multi-cycle data-memory waits and halt/resume requests.
- Keeps stall and flush performance counters and a sticky memory-timeout error.
- Sits beside the datapath; all stage registers consume its enables in the same cycle.

Parameters:
- REG_AW, 5, register-index width.
- MEM_TIMEOUT, 15, MEM_WAIT cycles before mem_timeout_err sets.
- DRAIN_CYC, 4, bubble cycles needed to empty ID..WB on halt.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ifid_rs1  in  REG_AW  rs1 of instruction in IF/ID.
- ifid_rs2  in  REG_AW  rs2 of instruction in IF/ID.
- idex_memread  in  1  MemRead of ID/EX.
- idex_rd  in  REG_AW  rd of ID/EX.
- ex_branch_taken  in  1  resolved taken branch/jump in EX (Branch&cond | ForceBranch).
- exmem_memreq  in  1  EX/MEM MemRead|MemWrite.
- dmem_ready  in  1  data memory completes access this cycle.
- halt_req  in  1  request to drain and halt (pulse or level).
- resume  in  1  leave HALT.
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1 each  stage register write enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble (all-zero control) into the stage register.
- mem_timeout_err  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of branch flushes.
- state_o  out  3  FSM state: INIT=0, RUN=1, MEM_WAIT=2, DRAIN=3, HALT=4.

Behaviour:
- State, counters, drain/wait counters and error flag are registered.
- Enables and flushes are combinational from the current state and inputs, and act in the same cycle.
- Reset (rst_n=0, async):
  - state=INIT; counters=0; mem_timeout_err=0.
  - In INIT: all *_we=0, all *_flush=1.
  - INIT always goes to RUN after one clock.
- Default (RUN, no event): all *_we=1, all flush=0.
- Hazard terms:
  - memstall = exmem_memreq & ~dmem_ready.
  - loaduse = idex_memread & (idex_rd!=0) & (idex_rd==ifid_rs1 | idex_rd==ifid_rs2).
- RUN priority (highest first):
  1. memstall: pc/ifid/idex/exmem_we=0; memwb_we=1, memwb_flush=1; next MEM_WAIT; wait counter=1.
  2. ex_branch_taken: ifid_flush=1, idex_flush=1, all we=1 (PC loads target); flush_cnt+1.
  3. loaduse: pc_we=0, ifid_we=0, idex_flush=1; others we=1; single bubble.
  4. halt_req, with none of 1-3 active: normal advance this cycle; next DRAIN with drain counter=0.
- Branch and load-use cannot coincide: a taken branch flushes IF/ID, so branch wins.
- MEM_WAIT:
  - dmem_ready=0: same freeze outputs as RUN rule 1; wait counter+1 (saturates at MEM_TIMEOUT).
  - Wait counter reaching MEM_TIMEOUT sets mem_timeout_err. The flag stays set until reset; no forced release.
  - dmem_ready=1: cycle evaluated exactly as RUN (rules 2-4 apply) and the next state follows the RUN rules.
  - halt_req seen during MEM_WAIT is latched and acted on in the release cycle.
- DRAIN:
  - Outputs: pc_we=0, ifid_we=1, ifid_flush=1, others we=1; drain counter+1.
  - Counter reaching DRAIN_CYC gives next HALT.
  - memstall takes priority (freeze as MEM_WAIT, drain counter holds; returns to DRAIN when ready).
  - loaduse: pc_we=0, ifid_we=0, ifid_flush=0, idex_flush=1; counter holds.
  - ex_branch_taken: pc_we=1 for that cycle only, ifid/idex_flush=1; counter restarts at 0.
- HALT: all *_we=0, no flush. resume=1 gives next RUN (fetch restarts at held PC). halt_req is ignored.
- stall_cnt increments each cycle pc_we=0 in RUN or MEM_WAIT. Not in INIT/DRAIN/HALT.
- Both counters saturate at 2^CNT_W-1 (no wrap).
- rst_n asserted in any state (including mid-MEM_WAIT/DRAIN) immediately forces INIT outputs.

Test Plan:
- Reset during MEM_WAIT with stall_cnt=3 -> same-cycle all we=0, all flush=1, state_o=0, stall_cnt=0; state_o=1 one clock after rst_n rises.
- idex_memread=1, idex_rd=5, ifid_rs2=5 -> exactly one cycle pc_we=0, ifid_we=0, idex_flush=1, stall_cnt 0->1. Repeat with idex_rd=0 -> no stall.
- exmem_memreq=1, dmem_ready low 3 cycles, ex_branch_taken=1 held -> 3 freeze cycles with memwb_flush=1. Ready cycle: ifid/idex_flush=1, all we=1. stall_cnt=3, flush_cnt=1, state_o returns to 1.
- MEM_TIMEOUT=15, dmem_ready low 20 cycles -> mem_timeout_err rises after 15th wait cycle and stays 1 after ready.
- halt_req pulse in RUN -> 4 DRAIN cycles (pc_we=0, ifid_flush=1), then HALT with all we=0. resume -> RUN, pc_we=1 next cycle.
- CNT_W=4, force 20 load-use stalls -> stall_cnt=15, no wrap.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage RV32I pipeline: stage-register write enables and
// bubble inserts, load-use / branch / data-memory-wait / halt handling and perf counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int DRAIN_CYC   = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ifid_rs1,
    input  logic [REG_AW-1:0] ifid_rs2,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              ex_branch_taken,
    input  logic              exmem_memreq,
    input  logic              dmem_ready,
    input  logic              halt_req,
    input  logic              resume,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_we,
    output logic              exmem_we,
    output logic              memwb_we,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              memwb_flush,
    output logic              mem_timeout_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [2:0]        state_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int DRN_W  = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_RUN      = 3'd1,
        S_MEM_WAIT = 3'd2,
        S_DRAIN    = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic [DRN_W-1:0]   drain_cnt, drain_nxt;
    logic               halt_pend, halt_pend_nxt;
    logic               memstall, loaduse, halt_eff, freeze;
    logic               stall_inc, flush_inc;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [WAIT_W-1:0] sat_wait(input logic [WAIT_W-1:0] v);
        return (v == WAIT_W'(MEM_TIMEOUT)) ? v : v + WAIT_W'(1);
    endfunction

    assign memstall = exmem_memreq & ~dmem_ready;
    assign loaduse  = idex_memread & (idex_rd != '0) &
                      ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));
    assign halt_eff = halt_req | halt_pend;
    // Once parked in MEM_WAIT only the memory handshake releases the freeze.
    assign freeze   = (state == S_MEM_WAIT) ? ~dmem_ready : memstall;

    always_comb begin
        pc_we         = 1'b1;
        ifid_we       = 1'b1;
        idex_we       = 1'b1;
        exmem_we      = 1'b1;
        memwb_we      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        memwb_flush   = 1'b0;
        state_nxt     = state;
        wait_nxt      = '0;
        drain_nxt     = drain_cnt;
        halt_pend_nxt = halt_pend;
        flush_inc     = 1'b0;

        case (state)
            S_RUN, S_MEM_WAIT: begin
                if (freeze) begin
                    {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
                    memwb_flush = 1'b1;
                    wait_nxt    = sat_wait(wait_cnt);
                    state_nxt   = S_MEM_WAIT;
                    if (halt_req) halt_pend_nxt = 1'b1;
                end else if (ex_branch_taken) begin
                    ifid_flush    = 1'b1;
                    idex_flush    = 1'b1;
                    flush_inc     = 1'b1;
                    state_nxt     = S_RUN;
                    halt_pend_nxt = halt_eff;
                end else if (loaduse) begin
                    pc_we         = 1'b0;
                    ifid_we       = 1'b0;
                    idex_flush    = 1'b1;
                    state_nxt     = S_RUN;
                    halt_pend_nxt = halt_eff;
                end else if (halt_eff) begin
                    state_nxt     = S_DRAIN;
                    drain_nxt     = '0;
                    halt_pend_nxt = 1'b0;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (memstall) begin
                    {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
                    memwb_flush = 1'b1;
                    wait_nxt    = sat_wait(wait_cnt);
                end else if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                    drain_nxt  = '0;
                end else if (loaduse) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                end else begin
                    pc_we      = 1'b0;
                    ifid_flush = 1'b1;
                    drain_nxt  = drain_cnt + DRN_W'(1);
                    if (drain_nxt == DRN_W'(DRAIN_CYC)) state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
                halt_pend_nxt = 1'b0;
                if (resume) state_nxt = S_RUN;
            end
            default: begin
                {pc_we, ifid_we, idex_we, exmem_we, memwb_we}    = 5'b00000;
                {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'b1111;
                halt_pend_nxt = 1'b0;
                state_nxt     = S_RUN;
            end
        endcase
    end

    assign stall_inc = ~pc_we & ((state == S_RUN) | (state == S_MEM_WAIT));
    assign state_o   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_INIT;
            wait_cnt        <= '0;
            drain_cnt       <= '0;
            halt_pend       <= 1'b0;
            mem_timeout_err <= 1'b0;
            stall_cnt       <= '0;
            flush_cnt       <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            drain_cnt <= drain_nxt;
            halt_pend <= halt_pend_nxt;
            if (wait_nxt == WAIT_W'(MEM_TIMEOUT)) mem_timeout_err <= 1'b1;
            if (stall_inc) stall_cnt <= sat_cnt(stall_cnt);
            if (flush_inc) flush_cnt <= sat_cnt(flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle expected enable/flush/state vectors
// go through a scoreboard queue; counters and error flag are checked at step points.
module tb_pipe_hazard_ctrl;

    localparam logic [8:0] RUNV  = 9'b11111_0000;
    localparam logic [8:0] INITV = 9'b00000_1111;
    localparam logic [8:0] FRZ   = 9'b00001_0001;
    localparam logic [8:0] BR    = 9'b11111_1100;
    localparam logic [8:0] LU    = 9'b00111_0100;
    localparam logic [8:0] DRV   = 9'b01111_1000;
    localparam logic [8:0] HLT   = 9'b00000_0000;

    typedef struct packed {
        logic [8:0] ctl;
        logic [2:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
    logic idex_memread, ex_branch_taken, exmem_memreq, dmem_ready, halt_req, resume;
    logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic mem_timeout_err;
    logic [3:0] stall_cnt, flush_cnt;
    logic [2:0] state_o;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;

    pipe_hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(15), .DRAIN_CYC(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ex_branch_taken(ex_branch_taken), .exmem_memreq(exmem_memreq),
        .dmem_ready(dmem_ready), .halt_req(halt_req), .resume(resume),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
        .exmem_we(exmem_we), .memwb_we(memwb_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .mem_timeout_err(mem_timeout_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [8:0] ctl_now();
        return {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                ifid_flush, idex_flush, exmem_flush, memwb_flush};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 after inputs are set; checks outputs mid-cycle, then advances.
    task automatic cyc(input string tag, input logic [8:0] ctl, input logic [2:0] st);
        exp_t e;
        e.ctl = ctl;
        e.st  = st;
        sb_q.push_back(e);
        #3;
        e = sb_q.pop_front();
        chk({tag, ".ctl"}, 16'(ctl_now()), 16'(e.ctl));
        chk({tag, ".st"}, 16'(state_o), 16'(e.st));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifid_rs1 = '0; ifid_rs2 = '0; idex_rd = '0; idex_memread = 1'b0;
        ex_branch_taken = 1'b0; exmem_memreq = 1'b0; dmem_ready = 1'b1;
        halt_req = 1'b0; resume = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst.ctl", 16'(ctl_now()), 16'(INITV));
        chk("rst.stall", 16'(stall_cnt), 16'd0);
        chk("rst.flush", 16'(flush_cnt), 16'd0);
        chk("rst.err", 16'(mem_timeout_err), 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("rst_rel", INITV, 3'd0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc("init_held", INITV, 3'd0);
        rst_n = 1'b1;
        cyc("init_rel", INITV, 3'd0);
        cyc("run_idle", RUNV, 3'd1);

        // load-use on rs2, then rd=0 must not stall
        idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5; ifid_rs1 = 5'd7;
        cyc("lu_hit", LU, 3'd1);
        idex_memread = 1'b0;
        cyc("lu_after", RUNV, 3'd1);
        chk("lu.stall", 16'(stall_cnt), 16'd1);
        idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
        cyc("lu_x0", RUNV, 3'd1);
        chk("lu_x0.stall", 16'(stall_cnt), 16'd1);

        // memory wait with a taken branch held: memory freeze wins until ready
        do_reset();
        exmem_memreq = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
        cyc("mw1", FRZ, 3'd1);
        cyc("mw2", FRZ, 3'd2);
        cyc("mw3", FRZ, 3'd2);
        dmem_ready = 1'b1;
        cyc("mw_rel", BR, 3'd2);
        exmem_memreq = 1'b0; ex_branch_taken = 1'b0;
        cyc("mw_back", RUNV, 3'd1);
        chk("mw.stall", 16'(stall_cnt), 16'd3);
        chk("mw.flush", 16'(flush_cnt), 16'd1);

        // asynchronous reset in the middle of MEM_WAIT
        do_reset();
        exmem_memreq = 1'b1; dmem_ready = 1'b0;
        for (int i = 1; i <= 3; i++) cyc("mw_pre", FRZ, (i == 1) ? 3'd1 : 3'd2);
        chk("mw_pre.stall", 16'(stall_cnt), 16'd3);
        chk("mw_pre.st", 16'(state_o), 16'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.ctl", 16'(ctl_now()), 16'(INITV));
        chk("arst.st", 16'(state_o), 16'd0);
        chk("arst.stall", 16'(stall_cnt), 16'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
        cyc("arst_rel", INITV, 3'd0);
        cyc("arst_run", RUNV, 3'd1);

        // timeout: 20 wait cycles, flag after the 15th, sticky after release
        exmem_memreq = 1'b1; dmem_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cyc("to_wait", FRZ, (i == 1) ? 3'd1 : 3'd2);
            if (i == 14) chk("to.err14", 16'(mem_timeout_err), 16'd0);
            if (i == 15) chk("to.err15", 16'(mem_timeout_err), 16'd1);
        end
        dmem_ready = 1'b1;
        cyc("to_rel", RUNV, 3'd2);
        exmem_memreq = 1'b0;
        cyc("to_run", RUNV, 3'd1);
        chk("to.sticky", 16'(mem_timeout_err), 16'd1);
        chk("to.stall_sat", 16'(stall_cnt), 16'd15);

        // halt pulse: 4 drain cycles, halt, resume
        do_reset();
        halt_req = 1'b1;
        cyc("h_req", RUNV, 3'd1);
        halt_req = 1'b0;
        for (int i = 0; i < 4; i++) cyc("h_drain", DRV, 3'd3);
        cyc("h_halt", HLT, 3'd4);
        halt_req = 1'b1;
        cyc("h_ignore", HLT, 3'd4);
        halt_req = 1'b0; resume = 1'b1;
        cyc("h_resume", HLT, 3'd4);
        resume = 1'b0;
        cyc("h_run", RUNV, 3'd1);
        chk("h.stall", 16'(stall_cnt), 16'd0);

        // halt seen during memory wait is acted on at release
        exmem_memreq = 1'b1; dmem_ready = 1'b0;
        cyc("hl_mw1", FRZ, 3'd1);
        halt_req = 1'b1;
        cyc("hl_mw2", FRZ, 3'd2);
        halt_req = 1'b0; dmem_ready = 1'b1; exmem_memreq = 1'b0;
        cyc("hl_rel", RUNV, 3'd2);
        cyc("hl_drain", DRV, 3'd3);

        // stall counter saturation with CNT_W=4
        do_reset();
        idex_memread = 1'b1; idex_rd = 5'd9; ifid_rs1 = 5'd9;
        for (int i = 0; i < 20; i++) cyc("sat_lu", LU, 3'd1);
        chk("sat.stall", 16'(stall_cnt), 16'd15);
        idle_inputs();
        cyc("sat_run", RUNV, 3'd1);
        chk("sat.hold", 16'(stall_cnt), 16'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
